// File: rtl/ps2_key_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_framer: PS/2 deframer folding E0/F0 prefixes into an 11-bit key    |
// | event word; define PS2_PARITY_CHECK_EN to drop odd-parity failures. Rev 1.0 |
// +----------------------------------------------------------------------------+
module ps2_key_framer #(
  parameter int FILT    = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_err
);

  localparam logic [3:0]    FILT_LAST = 4'(FILT - 1);
  localparam int            TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } bit_state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_fclk, r_fall;
  logic [3:0]    r_filt_cnt;
  logic [TW-1:0] r_to_cnt;

  bit_state_t    r_state, w_state_nx;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_par, w_par_nx;
  logic [7:0]    w_byte_nx;
  logic          w_valid_nx, w_err_nx;
  logic          w_timeout, w_par_bad;

  logic          r_ext, r_rel, w_ext_nx, w_rel_nx;
  logic [10:0]   w_key_nx;

  // Synchronizers idle high so reset release does not look like a falling edge
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_fclk     <= 1'b1;
      r_fall     <= 1'b0;
      r_filt_cnt <= 4'd0;
    end else begin
      r_fall <= r_fclk && !r_clk_s2 && (r_filt_cnt == FILT_LAST);
      if (r_clk_s2 == r_fclk) begin
        r_filt_cnt <= 4'd0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_fclk     <= r_clk_s2;
        r_filt_cnt <= 4'd0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_fall) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_LAST) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign w_timeout = (r_state != IDLE) && !r_fall && (r_to_cnt == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_bad = ~(^{r_shift, r_par});
`else
  // Parity bit is captured but never allowed to reject a byte
  assign w_par_bad = 1'b0 & ~(^{r_shift, r_par});
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt;
    w_shift_nx   = r_shift;
    w_par_nx     = r_par;
    w_byte_nx    = rx_byte;
    w_valid_nx   = 1'b0;
    w_err_nx     = 1'b0;
    if (r_fall) begin
      case (r_state)
        IDLE: begin
          if (!r_dat_s2) begin
            w_state_nx   = DATA;
            w_bit_cnt_nx = 3'd0;
          end
        end
        DATA: begin
          w_shift_nx   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_nx = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nx = PARITY;
        end
        PARITY: begin
          w_par_nx   = r_dat_s2;
          w_state_nx = STOP;
        end
        STOP: begin
          w_state_nx = IDLE;
          if (!r_dat_s2 || w_par_bad) begin
            w_err_nx = 1'b1;
          end else begin
            w_valid_nx = 1'b1;
            w_byte_nx  = r_shift;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nx = IDLE;
      w_err_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_par     <= 1'b0;
      rx_byte   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_shift   <= w_shift_nx;
      r_par     <= w_par_nx;
      rx_byte   <= w_byte_nx;
      rx_valid  <= w_valid_nx;
      frame_err <= w_err_nx;
    end
  end

  // Keyboard protocol replies (ACK, BAT, echo, resend, errors) never become key events
  always_comb begin
    w_ext_nx = r_ext;
    w_rel_nx = r_rel;
    w_key_nx = ps2_key;
    if (rx_valid) begin
      case (rx_byte)
        8'hE0: w_ext_nx = 1'b1;
        8'hF0: w_rel_nx = 1'b1;
        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
          w_ext_nx = 1'b0;
          w_rel_nx = 1'b0;
        end
        default: begin
          w_key_nx = {~ps2_key[10], ~r_rel, r_ext, rx_byte};
          w_ext_nx = 1'b0;
          w_rel_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ext   <= 1'b0;
      r_rel   <= 1'b0;
      ps2_key <= 11'd0;
    end else begin
      r_ext   <= w_ext_nx;
      r_rel   <= w_rel_nx;
      ps2_key <= w_key_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_framer.sv
`default_nettype none
// tb_ps2_key_framer: directed table, timing/corner sequences and random frames
// checked against a byte-level model of the key event rules.
module tb_ps2_key_framer;

  localparam int FILT    = 4;
  localparam int TIMEOUT = 200;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;

  ps2_key_framer #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_key     (ps2_key),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_total = 0;
  int          n_pass = 0;
  int          n_valid = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          valid_cyc = -10;
  int          half = 10;
  logic [7:0]  last_rx = 8'd0;
  logic [10:0] prev_key = 11'd0;

  logic [10:0] m_key = 11'd0;
  logic        m_ext = 1'b0;
  logic        m_rel = 1'b0;
  logic [7:0]  discard_set [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  typedef struct {
    logic [7:0]  data;
    bit          bad_par;
    bit          bad_stop;
    logic [10:0] exp_key;
    int          exp_v;
    int          exp_e;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk_sys) begin
    if (reset) begin
      prev_key = 11'd0;
    end else begin
      if (rx_valid) begin
        n_valid++;
        last_rx   = rx_byte;
        valid_cyc = cyc;
      end
      if (frame_err) n_err++;
      if (ps2_key !== prev_key) begin
        chk("key_one_cycle_after_rx_valid", cyc, valid_cyc + 1);
        prev_key = ps2_key;
      end
    end
    cyc++;
  end

  function automatic bit is_discard(input logic [7:0] b);
    foreach (discard_set[i]) if (discard_set[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      if (!is_discard(b)) m_key = {~m_key[10], ~m_rel, m_ext, b};
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data_in = bits[i];
      repeat (half) @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      repeat (half) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
    end
  endtask

  task automatic send_and_check(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                input logic [10:0] exp_key, input int exp_v, input int exp_e,
                                input string tag);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_bits(frame_bits(b, bad_par, bad_stop), 11);
    ps2_data_in = 1'b1;
    repeat (6) @(posedge clk_sys);
    #1;
    chk({tag, "_key"}, ps2_key, exp_key);
    chk({tag, "_valid_count"}, n_valid - v0, exp_v);
    chk({tag, "_err_count"}, n_err - e0, exp_e);
    if (exp_v == 1) chk({tag, "_rx_byte"}, last_rx, b);
    repeat ($urandom_range(5, 30)) @(posedge clk_sys);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0, e0;
    logic [7:0] b;
    bit bp, bs;
    int ev, ee;

    vt[0]  = '{8'hF0, 1'b0, 1'b0, 11'h61C, 1, 0};
    vt[1]  = '{8'h1C, 1'b0, 1'b0, 11'h01C, 1, 0};
    vt[2]  = '{8'hE0, 1'b0, 1'b0, 11'h01C, 1, 0};
    vt[3]  = '{8'h75, 1'b0, 1'b0, 11'h775, 1, 0};
    vt[4]  = '{8'hE0, 1'b0, 1'b0, 11'h775, 1, 0};
    vt[5]  = '{8'hF0, 1'b0, 1'b0, 11'h775, 1, 0};
    vt[6]  = '{8'h6B, 1'b0, 1'b0, 11'h16B, 1, 0};
    vt[7]  = '{8'hE0, 1'b0, 1'b0, 11'h16B, 1, 0};
    vt[8]  = '{8'hFA, 1'b0, 1'b0, 11'h16B, 1, 0};
    vt[9]  = '{8'h29, 1'b0, 1'b0, 11'h629, 1, 0};
    vt[10] = '{8'h1C, 1'b0, 1'b1, 11'h629, 0, 1};
`ifdef PS2_PARITY_CHECK_EN
    vt[11] = '{8'h1C, 1'b1, 1'b0, 11'h629, 0, 1};
`else
    vt[11] = '{8'h1C, 1'b1, 1'b0, 11'h21C, 1, 0};
`endif

    repeat (5) @(negedge clk_sys);
    reset = 1'b0;
    @(posedge clk_sys);
    #1;
    chk("reset_ps2_key", ps2_key, 11'h000);
    chk("reset_rx_byte", rx_byte, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    repeat (10) @(negedge clk_sys);

    // Make code with exact cycle timing from the stop-bit clock edge
    half = 10;
    send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 10);
    ps2_data_in = 1'b1;
    repeat (half) @(negedge clk_sys);
    ps2_clk_in = 1'b0;
    repeat (2 + FILT) @(posedge clk_sys);
    #1;
    chk("stop_fall_no_valid_yet", rx_valid, 1'b0);
    @(posedge clk_sys);
    #1;
    chk("stop_valid_pulse", rx_valid, 1'b1);
    chk("stop_rx_byte", rx_byte, 8'h1C);
    chk("stop_key_not_yet", ps2_key, 11'h000);
    @(posedge clk_sys);
    #1;
    chk("make_key", ps2_key, 11'h61C);
    chk("valid_single_cycle", rx_valid, 1'b0);
    repeat (half) @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    model_byte(8'h1C);
    repeat (20) @(posedge clk_sys);

    for (int i = 0; i < 12; i++) begin
      half = 8 + i;
      send_and_check(vt[i].data, vt[i].bad_par, vt[i].bad_stop, vt[i].exp_key,
                     vt[i].exp_v, vt[i].exp_e, $sformatf("vec%0d", i));
      if (vt[i].exp_v == 1) model_byte(vt[i].data);
    end

    // Abort after four data bits; only the timeout can resolve it
    half = 12;
    v0 = n_valid;
    e0 = n_err;
    send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5);
    ps2_data_in = 1'b1;
    repeat (TIMEOUT + 20) @(posedge clk_sys);
    #1;
    chk("abort_err_count", n_err - e0, 1);
    chk("abort_valid_count", n_valid - v0, 0);
    chk("abort_key", ps2_key, m_key);
    model_byte(8'h29);
    send_and_check(8'h29, 1'b0, 1'b0, m_key, 1, 0, "after_abort");

    // Clock glitch one cycle short of the filter length, with data low
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk_sys);
    ps2_data_in = 1'b0;
    ps2_clk_in  = 1'b0;
    repeat (FILT - 1) @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (10) @(negedge clk_sys);
    ps2_data_in = 1'b1;
    repeat (10) @(posedge clk_sys);
    #1;
    chk("glitch_err_count", n_err - e0, 0);
    chk("glitch_valid_count", n_valid - v0, 0);
    model_byte(8'h3A);
    send_and_check(8'h3A, 1'b0, 1'b0, m_key, 1, 0, "after_glitch");

    // Reset in the middle of a frame
    send_bits(frame_bits(8'h33, 1'b0, 1'b0), 4);
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    chk("midreset_ps2_key", ps2_key, 11'h000);
    chk("midreset_rx_byte", rx_byte, 8'h00);
    chk("midreset_rx_valid", rx_valid, 1'b0);
    chk("midreset_frame_err", frame_err, 1'b0);
    repeat (5) @(negedge clk_sys);
    reset = 1'b0;
    v0 = n_valid;
    e0 = n_err;
    repeat (TIMEOUT + 20) @(posedge clk_sys);
    #1;
    chk("midreset_no_err", n_err - e0, 0);
    chk("midreset_no_valid", n_valid - v0, 0);
    m_key = 11'd0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    model_byte(8'h29);
    send_and_check(8'h29, 1'b0, 1'b0, m_key, 1, 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      half = $urandom_range(8, 20);
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = discard_set[$urandom_range(0, 5)];
        default: b = 8'($urandom);
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 9) == 0);
`ifdef PS2_PARITY_CHECK_EN
      ev = (bs || bp) ? 0 : 1;
`else
      ev = bs ? 0 : 1;
`endif
      ee = 1 - ev;
      if (ev == 1) model_byte(b);
      send_and_check(b, bp, bs, m_key, ev, ee, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
